rssb_control: RTL and testbench
===============================

Name:
rssb_control

Overview:
- Control FSM for the single-instruction RSSB (reverse-subtract-and-skip-if-borrow) processor.
- Sequences each instruction through three phases:
  - operand fetch;
  - execute: acc/mem write of mem[op1] − acc;
  - PC update: +1, or +2 on negative result.
- Drives datapath enables and muxes; samples the ALU sign flag `neg`.
- Sits between the PC/OP1/ACC registers, the memory and the ALU in the RSSB top level.

Parameters:
- none (fixed 2-bit state encoding)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- neg  input  1  ALU sign of (mem[op1] − acc); valid combinationally during EXEC
- write_op1  output  1  load OP1 register from memory read data
- write_acc  output  1  load ACC with ALU result
- write_mem  output  1  write ALU result to memory at selected address
- sel_pc  output  1  next-PC mux: 0 = PC+1, 1 = PC+2 (skip)
- sel_mem  output  1  memory address mux: 0 = PC, 1 = OP1
- write_pc  output  1  load PC from next-PC mux

Behaviour:
- Internal state: 2-bit FSM and a 1-bit `neg_q` flag register, both asynchronously cleared while rst=0.
- States and transitions:
  - IDLE (00): reset state; unconditionally goes to FETCH on the next rising clk.
  - FETCH (01) → EXEC (10).
  - EXEC (10) → UPDATE (11).
  - UPDATE (11) → FETCH (01).
  - Steady-state period: 3 clocks per instruction; IDLE is never re-entered except via reset.
- Output decode is Moore-style from state, with `sel_pc` taken from `neg_q`.
- IDLE: all outputs 0.
- FETCH: sel_mem=0, write_op1=1; all others 0.
- EXEC:
  - sel_mem=1, write_acc=1, write_mem=1; all others 0.
  - At the rising edge ending EXEC, `neg_q` ← `neg`.
- UPDATE:
  - write_pc=1, sel_pc=`neg_q`; all others 0.
  - sel_mem=0, so the memory address returns to PC.
- `neg` is ignored outside EXEC; `neg_q` holds its value until the next EXEC.
- Reset:
  - rst=0: state=IDLE and `neg_q`=0 immediately, regardless of clk; all outputs 0 within the same delta.
  - Reset mid-instruction (any state) aborts the instruction; no write strobe may remain asserted.
  - After rst rises, the first FETCH occurs one clock later (IDLE → FETCH).
- Exactly one of write_op1 / {write_acc, write_mem} / write_pc is active per cycle; no two phases overlap.
- sel_pc is 0 in every state except UPDATE.
- Illegal or unknown state: none exists with 2 bits; the default decode branch drives all outputs 0 and next state IDLE.
- No combinational path from `neg` to any output.

Test Plan:
- Reset behaviour:
  - Hold rst=0 for 2 clocks → all six outputs 0, state IDLE.
  - Assert rst=0 asynchronously between edges while in EXEC → write_acc/write_mem drop to 0 immediately.
- Basic sequence with neg=0:
  - Release rst → cycle 1 IDLE outputs 0.
  - Cycle 2: write_op1=1, sel_mem=0.
  - Cycle 3: write_acc=write_mem=sel_mem=1.
  - Cycle 4: write_pc=1, sel_pc=0.
  - Cycle 5: back to write_op1=1.
- Skip path: neg=1 during EXEC → following UPDATE has write_pc=1, sel_pc=1; the next FETCH has sel_pc=0.
- neg sampling window:
  - neg=1 only during FETCH and UPDATE, 0 during EXEC → sel_pc=0 in UPDATE.
  - neg toggled every cycle → sel_pc in each UPDATE equals the neg level at the EXEC→UPDATE edge.
- Long run: 20 instructions with alternating neg per instruction → strict 3-cycle period, sel_pc alternates 0/1 per UPDATE, never two write strobes in the same cycle.

Source files
------------

// File: rtl/rssb_control.sv
// Control sequencer for the single-instruction RSSB processor: steps each
// instruction through operand fetch, execute and PC update.
module rssb_control (
  input  logic clk,
  input  logic rst,
  input  logic neg,
  output logic write_op1,
  output logic write_acc,
  output logic write_mem,
  output logic sel_pc,
  output logic sel_mem,
  output logic write_pc
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    EXEC   = 2'b10,
    UPDATE = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   neg_q, neg_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
    end
  end

  // The ALU sign is only meaningful while EXEC addresses mem[op1].
  always_comb begin
    neg_d = neg_q;
    if (state_q == EXEC) neg_d = neg;
  end

  always_comb begin
    state_d   = IDLE;
    write_op1 = 1'b0;
    write_acc = 1'b0;
    write_mem = 1'b0;
    sel_pc    = 1'b0;
    sel_mem   = 1'b0;
    write_pc  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        state_d   = EXEC;
        write_op1 = 1'b1;
      end
      EXEC: begin
        state_d   = UPDATE;
        sel_mem   = 1'b1;
        write_acc = 1'b1;
        write_mem = 1'b1;
      end
      UPDATE: begin
        state_d  = FETCH;
        write_pc = 1'b1;
        sel_pc   = neg_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rssb_control.sv
// Bench for rssb_control: fixed vector table, reset corner cases and a
// randomized run compared against a phase-counting reference model.
module tb_rssb_control;

  logic clk;
  logic rst;
  logic neg;
  logic write_op1, write_acc, write_mem, sel_pc, sel_mem, write_pc;
  logic [5:0] outv;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles since reset release and the captured sign.
  int mk    = 0;
  bit mflag = 1'b0;

  typedef struct {
    bit         r;
    bit         n;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[13];

  rssb_control dut (
    .clk       (clk),
    .rst       (rst),
    .neg       (neg),
    .write_op1 (write_op1),
    .write_acc (write_acc),
    .write_mem (write_mem),
    .sel_pc    (sel_pc),
    .sel_mem   (sel_mem),
    .write_pc  (write_pc)
  );

  assign outv = {write_op1, write_acc, write_mem, sel_pc, sel_mem, write_pc};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output order: {write_op1, write_acc, write_mem, sel_pc, sel_mem, write_pc}
  function automatic logic [5:0] model_out();
    if (mk == 0) return 6'b000000;
    case ((mk - 1) % 3)
      0:       return 6'b100000;
      1:       return 6'b011010;
      default: return {3'b000, mflag, 1'b0, 1'b1};
    endcase
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_strobes(input string name);
    int cnt;
    cnt = int'(write_op1) + int'(write_acc | write_mem) + int'(write_pc);
    checks++;
    if (cnt > 1) begin
      errors++;
      $display("FAIL %s: %0d write phases active, expected at most 1 at %0t", name, cnt, $time);
    end
  endtask

  // Drive inputs just after the falling edge, clock once, sample on the next falling edge.
  task automatic step(input bit r, input bit n);
    rst = r;
    neg = n;
    if (!r) begin
      mk    = 0;
      mflag = 1'b0;
    end
    @(posedge clk);
    if (r) begin
      if (mk >= 1 && (mk - 1) % 3 == 1) mflag = n;
      mk++;
      if (mk > 3) mk -= 3;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    neg = 1'b0;

    tbl[0]  = '{1'b0, 1'b0, 6'b000000};
    tbl[1]  = '{1'b0, 1'b0, 6'b000000};
    tbl[2]  = '{1'b1, 1'b0, 6'b100000};
    tbl[3]  = '{1'b1, 1'b0, 6'b011010};
    tbl[4]  = '{1'b1, 1'b0, 6'b000001};
    tbl[5]  = '{1'b1, 1'b1, 6'b100000};
    tbl[6]  = '{1'b1, 1'b1, 6'b011010};
    tbl[7]  = '{1'b1, 1'b1, 6'b000101};
    tbl[8]  = '{1'b1, 1'b0, 6'b100000};
    tbl[9]  = '{1'b1, 1'b1, 6'b011010};
    tbl[10] = '{1'b1, 1'b0, 6'b000001};
    tbl[11] = '{1'b1, 1'b1, 6'b100000};
    tbl[12] = '{1'b0, 1'b1, 6'b000000};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].n);
      chk($sformatf("table[%0d]", i), outv, tbl[i].exp);
    end

    // Still in IDLE right after release, before any rising edge.
    rst = 1'b1;
    #1;
    chk("idle_after_release", outv, 6'b000000);
    step(1'b1, 1'b0);
    chk("first_fetch", outv, 6'b100000);
    step(1'b1, 1'b1);
    chk("exec_before_abort", outv, 6'b011010);

    // Asynchronous reset between edges while executing.
    #2;
    rst   = 1'b0;
    mk    = 0;
    mflag = 1'b0;
    #1;
    chk("async_abort_exec", outv, 6'b000000);
    @(negedge clk);
    chk("held_reset", outv, 6'b000000);

    // neg_q must have been cleared by the abort: next UPDATE has no skip.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("update_after_abort", outv, 6'b000001);

    // neg toggling every cycle.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, bit'(i % 2));
      chk($sformatf("toggle[%0d]", i), outv, model_out());
    end

    // 20 instructions with alternating sign per instruction.
    step(1'b0, 1'b0);
    for (int i = 0; i < 61; i++) begin
      step(1'b1, bit'(((i + 2) / 3) % 2));
      chk($sformatf("long[%0d]", i), outv, model_out());
      chk_strobes($sformatf("long_strobe[%0d]", i));
    end

    // Randomized neg with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1, 1'($urandom));
      chk($sformatf("rand[%0d]", i), outv, model_out());
      chk_strobes($sformatf("rand_strobe[%0d]", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
